// File: rtl/instruction_issuer_pkg.sv
// -----------------------------------------------------------------------------
// instruction_issuer_pkg
// Shared definitions for the instruction issuer and its consumer side:
// field widths, the default halt opcode, FSM state codes and a word-packing
// helper. Word format: instruction[3:0] = opcode, instruction[7:4] = data.
// -----------------------------------------------------------------------------
package instruction_issuer_pkg;

    localparam int unsigned OPCODE_W    = 4;
    localparam int unsigned DATA_W      = 4;
    localparam int unsigned INSTR_W     = OPCODE_W + DATA_W;
    localparam int unsigned ISSUE_CNT_W = 8;

    localparam logic [OPCODE_W-1:0] HALT_OP_DEFAULT = 4'hF;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } issuer_state_e;

    function automatic logic [INSTR_W-1:0] pack_instr(
        input logic [OPCODE_W-1:0] opcode,
        input logic [DATA_W-1:0]   data
    );
        return {data, opcode};
    endfunction

endpackage

// File: rtl/instruction_issuer_fifo.sv
// -----------------------------------------------------------------------------
// instruction_issuer_fifo
// First-word-fall-through FIFO, DEPTH x WIDTH. The head entry is visible on
// o_data whenever the FIFO is non-empty; o_data reads zero when empty.
// Pushes into a full FIFO and pops from an empty one are ignored.
// Ports:
//   i_clock, i_reset   clock, asynchronous active-high reset
//   i_push, i_push_data  write request and word
//   i_pop              read request (advance head)
//   o_data             head entry (0 when empty)
//   o_count            entries held, 0..DEPTH
//   o_empty, o_full    occupancy flags
// -----------------------------------------------------------------------------
module instruction_issuer_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty,
    output logic                     o_full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage needs no reset: the output is masked while empty.
    always_ff @(posedge i_clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/instruction_issuer.sv
// -----------------------------------------------------------------------------
// instruction_issuer
// Producer side of the instruction register interface. Packs opcode/data
// nibbles into 8-bit words, buffers them in a FWFT FIFO and issues them over
// a valid/ready handshake. Accepting opcode HALT_OP stops intake until the
// queue has drained and i_resume is pulsed.
// Optional feature: define INSTR_ISSUER_PARITY_EN to add o_ins_parity
// (even parity of o_instruction, 0 when empty).
// Ports:
//   i_clock, i_reset     clock, asynchronous active-high reset
//   i_in_valid/o_in_ready  upstream handshake
//   i_in_opcode, i_in_data fields -> instruction[3:0] / instruction[7:4]
//   o_ins_valid/i_ins_ready downstream handshake
//   o_instruction        head of FIFO (8'h00 when empty)
//   o_fifo_count         entries held
//   o_halted             FSM is in HALTED
//   i_resume             leave HALTED, honoured only when empty
//   o_issue_count        instructions issued, wraps at 256
// -----------------------------------------------------------------------------
module instruction_issuer
    import instruction_issuer_pkg::*;
#(
    parameter int unsigned         DEPTH   = 4,
    parameter logic [OPCODE_W-1:0] HALT_OP = HALT_OP_DEFAULT
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_in_valid,
    output logic                   o_in_ready,
    input  logic [OPCODE_W-1:0]    i_in_opcode,
    input  logic [DATA_W-1:0]      i_in_data,
    output logic                   o_ins_valid,
    input  logic                   i_ins_ready,
    output logic [INSTR_W-1:0]     o_instruction,
    output logic [$clog2(DEPTH):0] o_fifo_count,
    output logic                   o_halted,
    input  logic                   i_resume,
    output logic [ISSUE_CNT_W-1:0] o_issue_count
`ifdef INSTR_ISSUER_PARITY_EN
    ,
    output logic                   o_ins_parity
`endif
);

    issuer_state_e          r_state;
    logic [ISSUE_CNT_W-1:0] r_issue_count;

    logic w_push;
    logic w_pop;
    logic w_empty;
    logic w_full;

    // in_ready depends only on registered state, never on i_ins_ready.
    assign o_in_ready  = (r_state == ST_RUN) && !w_full;
    assign o_ins_valid = !w_empty;
    assign w_push      = i_in_valid && o_in_ready;
    assign w_pop       = o_ins_valid && i_ins_ready;

    instruction_issuer_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_push      (w_push),
        .i_push_data (pack_instr(i_in_opcode, i_in_data)),
        .i_pop       (w_pop),
        .o_data      (o_instruction),
        .o_count     (o_fifo_count),
        .o_empty     (w_empty),
        .o_full      (w_full)
    );

    // The halting word itself is queued; intake stops from the next cycle.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_RUN;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_push && (i_in_opcode == HALT_OP)) begin
                        r_state <= ST_HALTED;
                    end
                end
                ST_HALTED: begin
                    if (i_resume && w_empty) begin
                        r_state <= ST_RUN;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_issue_count <= '0;
        end else if (w_pop) begin
            r_issue_count <= r_issue_count + ISSUE_CNT_W'(1);
        end
    end

    assign o_halted      = (r_state == ST_HALTED);
    assign o_issue_count = r_issue_count;

`ifdef INSTR_ISSUER_PARITY_EN
    // o_instruction is already zero when empty, so parity is too.
    assign o_ins_parity = o_ins_valid && (^o_instruction);
`endif

endmodule
